vu_display_scheduler: RTL and testbench



---
 rtl/vu_pkg.sv | 16 +
 rtl/vu_level_channel.sv | 60 ++++++
 rtl/vu_display_scheduler.sv | 111 +++++++++++
 tb/tb_vu_display_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vu_pkg.sv
// Shared colour constants and default parameters for the VU display scheduler.
// Colours are packed {red, green, blue}, four bits each.
package vu_pkg;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] WHITE  = 12'hFFF;

  localparam int DEF_LVL_W  = 8;
  localparam int DEF_YEL_TH = 160;
  localparam int DEF_RED_TH = 208;
  localparam int DEF_DECAY  = 30;

endpackage

// File: rtl/vu_level_channel.sv
// One level channel: handshake capture into a shadow register, a once-per-frame
// commit into the active level, and peak-hold with slow decay.
module vu_level_channel
  import vu_pkg::*;
#(
  parameter int LVL_W = DEF_LVL_W,
  parameter int DECAY = DEF_DECAY
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             commit,
  input  logic [LVL_W-1:0] level,
  input  logic             valid,
  output logic             ready,
  output logic [LVL_W-1:0] act,
  output logic [LVL_W-1:0] peak
);

  localparam int CNT_W = (DECAY > 1) ? $clog2(DECAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY - 1);

  logic [LVL_W-1:0] shadow;
  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic [LVL_W-1:0] new_lvl;

  // Refusing writes on the commit cycle keeps capture and commit from colliding.
  assign ready   = ~reset & ~commit;
  assign new_lvl = pend ? shadow : act;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      pend   <= 1'b0;
      act    <= '0;
      peak   <= '0;
      cnt    <= '0;
    end else begin
      if (valid && ready) begin
        shadow <= level;
        pend   <= 1'b1;
      end
      if (commit) begin
        act  <= new_lvl;
        pend <= 1'b0;
        if (new_lvl >= peak) begin
          peak <= new_lvl;
          cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
          // peak > new_lvl here, so peak-1 still bounds act from above
          peak <= peak - 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vu_display_scheduler.sv
// Frame-synchronous VU meter: commits level updates at the start of vertical
// blanking and renders two horizontal bar graphs through a one-cycle pixel pipeline.
module vu_display_scheduler
  import vu_pkg::*;
#(
  parameter int C_SIZE = 9,
  parameter int VADDR  = 480,
  parameter int LVL_W  = DEF_LVL_W,
  parameter int BAR_H  = 32,
  parameter int L_Y    = 160,
  parameter int R_Y    = 288,
  parameter int YEL_TH = DEF_YEL_TH,
  parameter int RED_TH = DEF_RED_TH,
  parameter int DECAY  = DEF_DECAY
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic [C_SIZE:0]   row,
  input  logic [C_SIZE:0]   column,
  input  logic              disp_enable,
  input  logic [LVL_W-1:0]  l_level,
  input  logic [LVL_W-1:0]  r_level,
  input  logic              l_valid,
  input  logic              r_valid,
  output logic              l_ready,
  output logic              r_ready,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              rgb_valid,
  output logic              frame_tick
);

  logic             commit;
  logic [LVL_W-1:0] act_l, act_r, peak_l, peak_r;
  logic [C_SIZE-1:0] p;
  logic [31:0]      row_w;
  logic             in_l, in_r;
  logic [11:0]      colour_next;

  assign commit = (32'(row) == 32'(VADDR)) && (column == '0);

  vu_level_channel #(.LVL_W(LVL_W), .DECAY(DECAY)) u_left (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .commit      (commit),
    .level       (l_level),
    .valid       (l_valid),
    .ready       (l_ready),
    .act         (act_l),
    .peak        (peak_l)
  );

  vu_level_channel #(.LVL_W(LVL_W), .DECAY(DECAY)) u_right (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .commit      (commit),
    .level       (r_level),
    .valid       (r_valid),
    .ready       (r_ready),
    .act         (act_r),
    .peak        (peak_r)
  );

  // Each level step is two pixels wide so a full-scale level fills most of the line.
  assign p     = column[C_SIZE:1];
  assign row_w = 32'(row);
  assign in_l  = (row_w >= 32'(L_Y)) && (row_w < 32'(L_Y + BAR_H));
  assign in_r  = (row_w >= 32'(R_Y)) && (row_w < 32'(R_Y + BAR_H));

  function automatic logic [11:0] bar_colour(input logic [C_SIZE-1:0] pos,
                                             input logic [LVL_W-1:0]  a,
                                             input logic [LVL_W-1:0]  pk);
    logic [31:0] pw, aw, kw;
    pw = 32'(pos);
    aw = 32'(a);
    kw = 32'(pk);
    if (kw != 32'd0 && pw == kw) return WHITE;
    if (pw < aw) begin
      if (pw < 32'(YEL_TH)) return GREEN;
      if (pw < 32'(RED_TH)) return YELLOW;
      return RED;
    end
    return BLACK;
  endfunction

  always_comb begin
    colour_next = BLACK;
    if (disp_enable) begin
      if (in_l)      colour_next = bar_colour(p, act_l, peak_l);
      else if (in_r) colour_next = bar_colour(p, act_r, peak_r);
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      rgb_valid  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      red        <= colour_next[11:8];
      green      <= colour_next[7:4];
      blue       <= colour_next[3:0];
      rgb_valid  <= disp_enable;
      frame_tick <= commit;
    end
  end

endmodule

// File: tb/tb_vu_display_scheduler.sv
// Directed bench for vu_display_scheduler: pixel vector tables after known commits,
// plus hand-written sequences for the commit-cycle handshake, reset and peak decay.
module tb_vu_display_scheduler;
  import vu_pkg::*;

  logic       pixel_clock = 1'b0;
  logic       reset;
  logic [9:0] row, column;
  logic       disp_enable;
  logic [7:0] l_level, r_level;
  logic       l_valid, r_valid;
  logic       l_ready, r_ready;
  logic [3:0] red, green, blue;
  logic       rgb_valid, frame_tick;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0]  row;
    logic [9:0]  col;
    logic        de;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[$];

  vu_display_scheduler dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .row         (row),
    .column      (column),
    .disp_enable (disp_enable),
    .l_level     (l_level),
    .r_level     (r_level),
    .l_valid     (l_valid),
    .r_valid     (r_valid),
    .l_ready     (l_ready),
    .r_ready     (r_ready),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .rgb_valid   (rgb_valid),
    .frame_tick  (frame_tick)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void add(input logic [9:0] r, input logic [9:0] c,
                              input logic de, input logic [11:0] rgb);
    vec_t v;
    v.row = r; v.col = c; v.de = de; v.rgb = rgb;
    tbl.push_back(v);
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      row = tbl[i].row; column = tbl[i].col; disp_enable = tbl[i].de;
      @(negedge pixel_clock);
      chk($sformatf("%s[%0d] rgb", tag, i), {19'b0, rgb_valid, red, green, blue},
          {19'b0, tbl[i].de, tbl[i].rgb});
    end
    tbl.delete();
  endtask

  task automatic pix(input string nm, input logic [9:0] r, input logic [9:0] c,
                     input logic [11:0] exp);
    add(r, c, 1'b1, exp);
    run_tbl(nm);
  endtask

  task automatic do_commit(input string nm);
    row = 10'd480; column = 10'd0; disp_enable = 1'b0;
    #1;
    chk({nm, " ready@commit"}, {30'b0, l_ready, r_ready}, 32'd0);
    @(negedge pixel_clock);
    chk({nm, " tick"}, {31'b0, frame_tick}, 32'd1);
    row = 10'd481; column = 10'd5;
    @(negedge pixel_clock);
    chk({nm, " tick_end"}, {31'b0, frame_tick}, 32'd0);
  endtask

  task automatic wr_l(input logic [7:0] v);
    row = 10'd10; column = 10'd3; disp_enable = 1'b1;
    l_level = v; l_valid = 1'b1;
    #1;
    chk("l_ready", {31'b0, l_ready}, 32'd1);
    @(negedge pixel_clock);
    l_valid = 1'b0;
  endtask

  task automatic wr_r(input logic [7:0] v);
    row = 10'd11; column = 10'd3; disp_enable = 1'b1;
    r_level = v; r_valid = 1'b1;
    #1;
    chk("r_ready", {31'b0, r_ready}, 32'd1);
    @(negedge pixel_clock);
    r_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge pixel_clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    row = '0; column = '0; disp_enable = 1'b0;
    l_level = '0; r_level = '0; l_valid = 1'b0; r_valid = 1'b0;
    repeat (3) @(negedge pixel_clock);
    chk("reset outputs", {18'b0, frame_tick, rgb_valid, red, green, blue}, 32'd0);
    chk("reset ready", {30'b0, l_ready, r_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after release", {30'b0, l_ready, r_ready}, 32'd3);
    @(negedge pixel_clock);

    // Level 100 accepted mid-frame: nothing until the commit.
    wr_l(8'd100);
    pix("pre_commit", 10'd170, 10'd100, BLACK);
    do_commit("c100");
    add(10'd170, 10'd199, 1'b1, GREEN);
    add(10'd170, 10'd200, 1'b1, WHITE);
    add(10'd170, 10'd201, 1'b1, WHITE);
    add(10'd170, 10'd202, 1'b1, BLACK);
    add(10'd170, 10'd0,   1'b1, GREEN);
    add(10'd170, 10'd200, 1'b0, BLACK);
    add(10'd159, 10'd10,  1'b1, BLACK);
    add(10'd160, 10'd10,  1'b1, GREEN);
    add(10'd191, 10'd10,  1'b1, GREEN);
    add(10'd192, 10'd10,  1'b1, BLACK);
    add(10'd300, 10'd10,  1'b1, BLACK);
    run_tbl("l100");

    // Full scale exercises every colour band.
    wr_l(8'd255);
    do_commit("c255");
    add(10'd170, 10'd318, 1'b1, GREEN);
    add(10'd170, 10'd320, 1'b1, YELLOW);
    add(10'd170, 10'd415, 1'b1, YELLOW);
    add(10'd170, 10'd416, 1'b1, RED);
    add(10'd170, 10'd508, 1'b1, RED);
    add(10'd170, 10'd510, 1'b1, WHITE);
    add(10'd170, 10'd511, 1'b1, WHITE);
    run_tbl("l255");

    // Valid offered on the commit cycle is held and taken one cycle later.
    row = 10'd480; column = 10'd0; disp_enable = 1'b0;
    l_level = 8'd60; l_valid = 1'b1;
    #1;
    chk("hold ready@commit", {31'b0, l_ready}, 32'd0);
    @(negedge pixel_clock);
    chk("hold tick", {31'b0, frame_tick}, 32'd1);
    column = 10'd1;
    #1;
    chk("hold ready next", {31'b0, l_ready}, 32'd1);
    @(negedge pixel_clock);
    l_valid = 1'b0;
    chk("hold tick_end", {31'b0, frame_tick}, 32'd0);
    pix("hold same frame", 10'd170, 10'd400, YELLOW);
    do_commit("c60");
    add(10'd170, 10'd119, 1'b1, GREEN);
    add(10'd170, 10'd120, 1'b1, BLACK);
    add(10'd170, 10'd510, 1'b1, WHITE);
    run_tbl("l60");

    // Independent channels, last write wins.
    pulse_reset();
    wr_l(8'd20);
    wr_r(8'd7);
    wr_l(8'd40);
    do_commit("c40_7");
    add(10'd170, 10'd40, 1'b1, GREEN);
    add(10'd170, 10'd79, 1'b1, GREEN);
    add(10'd170, 10'd80, 1'b1, WHITE);
    add(10'd170, 10'd82, 1'b1, BLACK);
    add(10'd300, 10'd13, 1'b1, GREEN);
    add(10'd300, 10'd14, 1'b1, WHITE);
    add(10'd300, 10'd16, 1'b1, BLACK);
    run_tbl("dual");

    // Reset mid-frame wipes the bars and discards a pending write.
    wr_l(8'd90);
    pix("pre_reset", 10'd170, 10'd10, GREEN);
    #2 reset = 1'b1;
    #1;
    chk("midreset rgb", {19'b0, rgb_valid, red, green, blue}, 32'd0);
    @(negedge pixel_clock);
    reset = 1'b0;
    do_commit("c_after_reset");
    add(10'd170, 10'd10,  1'b1, BLACK);
    add(10'd170, 10'd180, 1'b1, BLACK);
    add(10'd170, 10'd80,  1'b1, BLACK);
    add(10'd300, 10'd10,  1'b1, BLACK);
    run_tbl("post_reset");

    // Peak decay: marker holds for 29 commits, steps down on the 30th.
    wr_l(8'd50);
    do_commit("c50");
    pix("peak50", 10'd170, 10'd100, WHITE);
    for (int k = 1; k <= 30; k++) begin
      wr_l(8'd0);
      do_commit($sformatf("decay%0d", k));
      add(10'd170, 10'd100, 1'b1, (k < 30) ? WHITE : BLACK);
      add(10'd170, 10'd98,  1'b1, (k < 30) ? BLACK : WHITE);
      add(10'd170, 10'd0,   1'b1, BLACK);
      run_tbl($sformatf("decay%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
